fifo_read_drain: RTL and testbench
==================================

// Module: fifo_read_drain
// PURPOSE
//  Read-side controller for Async_FIFO. Runs entirely in the rd_clk domain.
//  - Pops words whenever r_empty is low.
//  - Holds them in a 2-entry skid buffer and presents them on a valid/ready stream.
//  - Checks the words against an incrementing data sequence and keeps error and word counts.
// PARAMETERS
//  DATA_W  8   FIFO word width; must match Async_FIFO data_out
//  CNT_W   16  width of word_cnt and err_cnt
// PORTS
//  rd_clk      in   1       read-domain clock, rising edge
//  reset       in   1       asynchronous, active-low (0 = reset)
//  r_empty     in   1       FIFO empty flag, synchronous to rd_clk
//  fifo_rd_en  out  1       pop request to the FIFO
//  fifo_data   in   DATA_W  FIFO read data, valid 1 cycle after fifo_rd_en
//  m_valid     out  1       output word available
//  m_ready     in   1       downstream accepts the word
//  m_data      out  DATA_W  output word
//  chk_en      in   1       sequence checker enable
//  seq_err     out  1       1-cycle pulse on a sequence mismatch
//  err_cnt     out  CNT_W   mismatch count, saturating
//  word_cnt    out  CNT_W   output transfer count, saturating
// BEHAVIOUR
//  Reset values:
//  - m_valid, seq_err = 0; m_data = 0; err_cnt, word_cnt = 0.
//  - Buffer emptied, in-flight flag cleared, checker unsynced.
//  - fifo_rd_en is combinationally 0 while reset = 0.
//  Definitions:
//  - inflight = registered fifo_rd_en.
//  - occ = number of held words, 0..2.
//  - pop = m_valid & m_ready.
//  fifo_rd_en = !r_empty & ((occ + inflight < 2) | (occ + inflight == 2 & pop)).
//  - occ + inflight never exceeds 2, so no word is ever dropped.
//  Latency:
//  - fifo_rd_en high in cycle N -> fifo_data captured at the end of N+1 -> m_valid high in N+2.
//  Throughput:
//  - With m_ready held high, 1 word per cycle is sustained.
//  Ordering:
//  - Strict FIFO order; m_data always shows the oldest held word.
//  - m_data is stable while m_valid & !m_ready (AXI-style: valid never drops without pop).
//  Occupancy FSM: EMPTY (occ=0), ONE (occ=1), FULL (occ=2).
//  - capture & !pop: EMPTY->ONE, ONE->FULL.
//  - pop & !capture: FULL->ONE, ONE->EMPTY.
//  - capture & pop together: state unchanged; the head advances.
//  - FULL with capture & !pop cannot occur (guaranteed by the fifo_rd_en rule).
//  Checker (evaluated on each captured word, only when chk_en = 1):
//  - Unsynced state: load expected = word + 1 and become synced. No error on this word.
//  - Synced, word == expected: expected <= word + 1.
//  - Synced, word != expected: seq_err = 1 for one cycle, err_cnt += 1, expected <= word + 1 (resync).
//  - All expected arithmetic is modulo 2^DATA_W, so 0xFF -> 0x00 is legal.
//  - chk_en = 0: checker goes unsynced; counts hold; seq_err = 0.
//  Counters:
//  - word_cnt increments on every pop.
//  - Both counters saturate at 2^CNT_W - 1 and never wrap.
//  Reset mid-operation:
//  - Held and in-flight words are discarded.
//  - The FIFO read pointer is not rewound.
//  - The first post-reset capture resyncs the checker.
//  r_empty rising while inflight = 1: the in-flight word is still captured.
// TESTING
//  1. Reset: reset = 0 with r_empty = 0 -> fifo_rd_en = 0, m_valid = 0, all counts 0.
//  2. Single word: r_empty low for 1 cycle, fifo_data = 0x05, m_ready = 1
//     -> m_valid for 1 cycle, 2 cycles after fifo_rd_en, m_data = 0x05, word_cnt = 1.
//  3. Backpressure: m_ready = 0 with the FIFO non-empty
//     -> exactly 2 pops, then fifo_rd_en = 0 and m_data holds the first word.
//     Then raise m_ready -> both words out in order, then streaming resumes at 1 word/cycle.
//  4. Wrap: sequence 0xFE, 0xFF, 0x00, 0x01 with chk_en = 1 -> err_cnt = 0, seq_err never high.
//  5. Error: sequence 0x10, 0x11, 0x13, 0x14 -> one seq_err pulse on 0x13, err_cnt = 1,
//     no error on 0x14.
//  6. Mid-stream reset with occ = 2 -> m_valid = 0 at once, counts 0;
//     after release, the next word is not flagged.

Source files
------------

// File: rtl/fifo_read_drain.sv
// Read-side drain for Async_FIFO: pops words into a 2-entry skid buffer,
// streams them on valid/ready and checks an incrementing data sequence.
module fifo_read_drain #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              rd_clk,
  input  logic              reset,
  input  logic              r_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  input  logic              chk_en,
  output logic              seq_err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  word_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e              state_q;
  logic              m_valid_q;
  logic              inflight_q;
  logic [DATA_W-1:0] head_q;
  logic [DATA_W-1:0] skid_q;

  logic              synced_q;
  logic [DATA_W-1:0] expect_q;
  logic              seq_err_q;
  logic [CNT_W-1:0]  err_cnt_q;
  logic [CNT_W-1:0]  word_cnt_q;

  logic       pop;
  logic       capture;
  logic [1:0] occ;
  logic [2:0] load;

  assign pop     = m_valid_q & m_ready;
  assign capture = inflight_q;
  assign occ     = state_q;
  assign load    = {1'b0, occ} + {2'b00, inflight_q};

  // A pop frees a slot this cycle, so a full load may still request.
  assign fifo_rd_en = reset & ~r_empty
                    & ((load < 3'd2) | ((load == 3'd2) & pop));

  assign m_valid  = m_valid_q;
  assign m_data   = head_q;
  assign seq_err  = seq_err_q;
  assign err_cnt  = err_cnt_q;
  assign word_cnt = word_cnt_q;

  always_ff @(posedge rd_clk or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      m_valid_q  <= 1'b0;
      inflight_q <= 1'b0;
      head_q     <= '0;
      skid_q     <= '0;
    end else begin
      inflight_q <= fifo_rd_en;
      unique case (state_q)
        EMPTY: begin
          if (capture) begin
            head_q    <= fifo_data;
            state_q   <= ONE;
            m_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (capture && pop) begin
            head_q <= fifo_data;
          end else if (capture) begin
            skid_q  <= fifo_data;
            state_q <= FULL;
          end else if (pop) begin
            state_q   <= EMPTY;
            m_valid_q <= 1'b0;
          end
        end
        FULL: begin
          if (pop) begin
            head_q <= skid_q;
            if (capture) begin
              skid_q <= fifo_data;
            end else begin
              state_q <= ONE;
            end
          end
        end
        default: begin
          state_q   <= EMPTY;
          m_valid_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge rd_clk or negedge reset) begin
    if (!reset) begin
      synced_q  <= 1'b0;
      expect_q  <= '0;
      seq_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      seq_err_q <= 1'b0;
      if (!chk_en) begin
        synced_q <= 1'b0;
      end else if (capture) begin
        synced_q <= 1'b1;
        expect_q <= fifo_data + DATA_W'(1);
        if (synced_q && (fifo_data != expect_q)) begin
          seq_err_q <= 1'b1;
          if (err_cnt_q != '1) begin
            err_cnt_q <= err_cnt_q + CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge rd_clk or negedge reset) begin
    if (!reset) begin
      word_cnt_q <= '0;
    end else if (pop && (word_cnt_q != '1)) begin
      word_cnt_q <= word_cnt_q + CNT_W'(1);
    end
  end

  a_load_bound: assert property (
    @(posedge rd_clk) disable iff (!reset) load <= 3'd2
  );

  a_no_overflow: assert property (
    @(posedge rd_clk) disable iff (!reset)
    !((state_q == FULL) && capture && !pop)
  );

endmodule

// File: tb/tb_fifo_read_drain.sv
// Bench for fifo_read_drain: a FIFO source model feeds words, a queue
// scoreboard checks the output stream, scenario tasks check the rest.
module tb_fifo_read_drain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        r_empty;
  logic        fifo_rd_en;
  bit   [7:0]  fifo_data;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        chk_en;
  logic        seq_err;
  logic [15:0] err_cnt;
  logic [15:0] word_cnt;

  logic        hold_empty;
  int unsigned rd_ptr;
  int unsigned wr_ptr;
  logic [7:0]  src_mem [256];
  logic [7:0]  exp_q [$];

  int checks;
  int failures;

  logic       obs_rd_en;
  logic       obs_valid;
  logic       obs_err;
  logic       obs_pop;
  logic [7:0] obs_data;

  fifo_read_drain #(.DATA_W(8), .CNT_W(16)) dut (
    .rd_clk     (clk),
    .reset      (reset),
    .r_empty    (r_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_data  (fifo_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .chk_en     (chk_en),
    .seq_err    (seq_err),
    .err_cnt    (err_cnt),
    .word_cnt   (word_cnt)
  );

  assign r_empty = hold_empty | (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (fifo_rd_en === 1'b1) begin
      fifo_data <= src_mem[rd_ptr[7:0]];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [7:0] w);
    src_mem[wr_ptr[7:0]] = w;
    wr_ptr = wr_ptr + 1;
    exp_q.push_back(w);
  endtask

  task automatic tick();
    logic [7:0] e;
    #1;
    obs_rd_en = fifo_rd_en;
    obs_valid = m_valid;
    obs_data  = m_data;
    obs_err   = seq_err;
    obs_pop   = m_valid & m_ready;
    if (obs_pop) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL stream: got %h, expected no word", m_data);
      end else begin
        e = exp_q.pop_front();
        if (m_data !== e) begin
          failures++;
          $display("FAIL stream: got %h, expected %h", m_data, e);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    m_ready    = 1'b0;
    chk_en     = 1'b0;
    hold_empty = 1'b0;
    src_mem[wr_ptr[7:0]] = 8'hAA;
    wr_ptr = wr_ptr + 1;
    @(negedge clk);
    #1;
    checks++;
    if (fifo_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL rst_rd_en: got %b, expected 0", fifo_rd_en);
    end
    checks++;
    if (m_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_valid: got %b, expected 0", m_valid);
    end
    checks++;
    if (m_data !== 8'h00) begin
      failures++;
      $display("FAIL rst_data: got %h, expected 00", m_data);
    end
    checks++;
    if (seq_err !== 1'b0) begin
      failures++;
      $display("FAIL rst_seq_err: got %b, expected 0", seq_err);
    end
    checks++;
    if (err_cnt !== 16'd0) begin
      failures++;
      $display("FAIL rst_err_cnt: got %0d, expected 0", err_cnt);
    end
    checks++;
    if (word_cnt !== 16'd0) begin
      failures++;
      $display("FAIL rst_word_cnt: got %0d, expected 0", word_cnt);
    end
    wr_ptr = rd_ptr;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single();
    int rd_at = -1;
    int v_at  = -1;
    int rd_n  = 0;
    int v_n   = 0;
    m_ready = 1'b1;
    push(8'h05);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (obs_rd_en) begin
        rd_n++;
        if (rd_at < 0) rd_at = i;
      end
      if (obs_valid) begin
        v_n++;
        if (v_at < 0) v_at = i;
      end
    end
    checks++;
    if (rd_n != 1) begin
      failures++;
      $display("FAIL single_pops: got %0d, expected 1", rd_n);
    end
    checks++;
    if (v_n != 1) begin
      failures++;
      $display("FAIL single_valid_len: got %0d, expected 1", v_n);
    end
    checks++;
    if (v_at - rd_at != 2) begin
      failures++;
      $display("FAIL single_latency: got %0d, expected 2", v_at - rd_at);
    end
    checks++;
    if (word_cnt !== 16'd1) begin
      failures++;
      $display("FAIL single_word_cnt: got %0d, expected 1", word_cnt);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL single_drain: got %0d left, expected 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int rd_n = 0;
    int bad  = 0;
    int pops = 0;
    m_ready = 1'b0;
    for (int w = 8'h20; w <= 8'h25; w++) push(8'(w));
    for (int i = 0; i < 6; i++) begin
      tick();
      if (obs_rd_en) rd_n++;
      if (obs_valid && (obs_data !== 8'h20)) bad++;
    end
    checks++;
    if (rd_n != 2) begin
      failures++;
      $display("FAIL bp_pops: got %0d, expected 2", rd_n);
    end
    checks++;
    if (obs_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL bp_rd_en: got %b, expected 0", obs_rd_en);
    end
    checks++;
    if (obs_valid !== 1'b1 || obs_data !== 8'h20) begin
      failures++;
      $display("FAIL bp_head: got v=%b d=%h, expected v=1 d=20",
               obs_valid, obs_data);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_stable: got %0d changes, expected 0", bad);
    end
    m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (obs_pop) pops++;
    end
    checks++;
    if (pops != 6) begin
      failures++;
      $display("FAIL bp_rate: got %0d pops in 6, expected 6", pops);
    end
    checks++;
    if (word_cnt !== 16'd7) begin
      failures++;
      $display("FAIL bp_word_cnt: got %0d, expected 7", word_cnt);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL bp_drain: got %0d left, expected 0", exp_q.size());
    end
  endtask

  task automatic test_wrap();
    int errs = 0;
    chk_en = 1'b1;
    push(8'hFE);
    push(8'hFF);
    push(8'h00);
    push(8'h01);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (obs_err) errs++;
    end
    checks++;
    if (errs != 0) begin
      failures++;
      $display("FAIL wrap_pulses: got %0d, expected 0", errs);
    end
    checks++;
    if (err_cnt !== 16'd0) begin
      failures++;
      $display("FAIL wrap_err_cnt: got %0d, expected 0", err_cnt);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL wrap_drain: got %0d left, expected 0", exp_q.size());
    end
  endtask

  task automatic test_error();
    int         errs  = 0;
    logic [7:0] err_d = 8'h00;
    chk_en = 1'b0;
    tick();
    chk_en = 1'b1;
    push(8'h10);
    push(8'h11);
    push(8'h13);
    push(8'h14);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (obs_err) begin
        errs++;
        err_d = obs_data;
      end
    end
    checks++;
    if (errs != 1) begin
      failures++;
      $display("FAIL err_pulses: got %0d, expected 1", errs);
    end
    checks++;
    if (err_d !== 8'h13) begin
      failures++;
      $display("FAIL err_word: got %h, expected 13", err_d);
    end
    checks++;
    if (err_cnt !== 16'd1) begin
      failures++;
      $display("FAIL err_cnt: got %0d, expected 1", err_cnt);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL err_drain: got %0d left, expected 0", exp_q.size());
    end
  endtask

  task automatic test_mid_reset();
    int vals = 0;
    int errs = 0;
    m_ready = 1'b0;
    push(8'h30);
    push(8'h31);
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (obs_valid !== 1'b1 || obs_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL mid_full: got v=%b rd=%b, expected v=1 rd=0",
               obs_valid, obs_rd_en);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_valid: got %b, expected 0", m_valid);
    end
    checks++;
    if (word_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      failures++;
      $display("FAIL mid_counts: got w=%0d e=%0d, expected 0 0",
               word_cnt, err_cnt);
    end
    exp_q.delete();
    @(negedge clk);
    reset   = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (obs_valid) vals++;
    end
    checks++;
    if (vals != 0) begin
      failures++;
      $display("FAIL mid_discard: got %0d valid cycles, expected 0", vals);
    end
    push(8'h90);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (obs_err) errs++;
    end
    checks++;
    if (errs != 0 || err_cnt !== 16'd0) begin
      failures++;
      $display("FAIL mid_resync: got pulses=%0d cnt=%0d, expected 0 0",
               errs, err_cnt);
    end
    checks++;
    if (word_cnt !== 16'd1) begin
      failures++;
      $display("FAIL mid_word_cnt: got %0d, expected 1", word_cnt);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL mid_drain: got %0d left, expected 0", exp_q.size());
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single();
    test_backpressure();
    test_wrap();
    test_error();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
